// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that sequences fetch and load/store onto one valid/ready memory port.
// Optional access timeout with sticky err flag: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic [DW-1:0] f_rdata,
   output logic          f_done,
   input  logic [1:0]    ls_op,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic [DW-1:0] ls_rdata,
   output logic          ls_done,
   output logic          m_valid,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic [DW-1:0] m_rdata,
   output logic          busy,
   output logic          owner,
   output logic          err
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LS = 2'd2, RESP = 2'd3} state_t;

   state_t        state, state_nx;
   logic          f_want, ls_want, grant_ls, to_hit, in_access;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_we;

   assign f_want    = f_req;
   assign ls_want   = (ls_op == 2'b01) || (ls_op == 2'b10);
   assign in_access = (state == FETCH) || (state == LS);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   assign to_hit = in_access && !m_ready && (wait_cnt == CW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (!in_access)
            wait_cnt <= '0;
         else if (!m_ready && !to_hit)
            wait_cnt <= wait_cnt + CW'(1);
         if (to_hit)
            err <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign to_hit         = 1'b0;
   assign err            = 1'b0;
`endif

   // On contention, owner remembers the last side served, so the other side wins.
   always_comb begin
      grant_ls = ls_want && !(f_want && owner);
      state_nx = state;
      case (state)
         IDLE: begin
            if (grant_ls)
               state_nx = LS;
            else if (f_want)
               state_nx = FETCH;
         end
         FETCH, LS: begin
            if (m_ready || to_hit)
               state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= 1'b1;
         f_rdata  <= '0;
         ls_rdata <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx != IDLE)
            owner <= grant_ls;
         if (state == FETCH) begin
            if (m_ready)
               f_rdata <= m_rdata;
            else if (to_hit)
               f_rdata <= '0;
         end
         if (state == LS && !req_we) begin
            if (m_ready)
               ls_rdata <= m_rdata;
            else if (to_hit)
               ls_rdata <= '0;
         end
      end
   end

   // Request payload is sampled every idle cycle; the value on the grant edge is what sticks.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         req_addr  <= grant_ls ? ls_addr : f_addr;
         req_wdata <= ls_wdata;
         req_we    <= grant_ls && (ls_op == 2'b10);
      end
   end

   assign m_valid = in_access;
   assign m_we    = req_we;
   assign m_addr  = req_addr;
   assign m_wdata = req_wdata;
   assign busy    = (state != IDLE);
   assign f_done  = (state == RESP) && !owner;
   assign ls_done = (state == RESP) && owner;

endmodule
